// File: rtl/pll_lock_pkg.sv
// Shared types and constants for the PLL lock qualifier.
package pll_lock_pkg;

    // Width of the qualification, timeout and hold-off counters.
    localparam int CNT_W = 16;

    // Width and ceiling of the loss event counter.
    localparam int                    LOSS_CNT_W   = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'hFF;

    // Qualifier FSM states.
    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        QUAL    = 2'd1,
        LOCKED  = 2'd2,
        HOLDOFF = 2'd3
    } lock_state_e;

    // Increment that sticks at the given ceiling instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                 input logic [CNT_W-1:0] ceil);
        sat_inc = (val >= ceil) ? ceil : val + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pll_lock_qualifier_if.sv
// Signal bundle around the PLL lock qualifier, seen from its user.
//
// Signal timing: pll_lock is a raw level with no relation to the clock.
// test_mode is a level. clr_status is a single-cycle pulse that takes effect
// on the next clock edge. lock, lock_lost, timeout and loss_cnt are registered
// except for the test_mode override on lock, which is combinational.
interface pll_lock_qualifier_if;
    import pll_lock_pkg::*;

    logic                  pll_lock;
    logic                  test_mode;
    logic                  clr_status;
    logic                  lock;
    logic                  lock_lost;
    logic                  timeout;
    logic [LOSS_CNT_W-1:0] loss_cnt;
    logic [1:0]            dbg_state;

    // Side that drives the PLL indication and control inputs.
    modport master (
        output pll_lock,
        output test_mode,
        output clr_status,
        input  lock,
        input  lock_lost,
        input  timeout,
        input  loss_cnt,
        input  dbg_state
    );

    // Side that implements the qualifier.
    modport slave (
        input  pll_lock,
        input  test_mode,
        input  clr_status,
        output lock,
        output lock_lost,
        output timeout,
        output loss_cnt,
        output dbg_state
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs.
// Synchronous active-low reset drives both stages to zero.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    // Next values of the two stages: input into stage one, stage one into two.
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Synchroniser flops.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_qualifier.sv
// PLL lock qualifier: turns a raw, glitchy lock indication into a clean lock
// level for the reset generator, with dropout filtering, hold-off after a
// genuine loss and sticky loss/timeout status.
module pll_lock_qualifier
    import pll_lock_pkg::*;
#(
    parameter int QUAL_CYCLES    = 1024,
    parameter int LOSS_FILTER    = 4,
    parameter int HOLDOFF_CYCLES = 256,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  pll_lock_i,
    input  logic                  test_mode_i,
    input  logic                  clr_status_i,
    output logic                  lock_o,
    output logic                  lock_lost_o,
    output logic                  timeout_o,
    output logic [LOSS_CNT_W-1:0] loss_cnt_o,
    output logic [1:0]            dbg_state_o
);

    // State encodings as plain vectors.
    localparam logic [1:0] ST_WAIT    = 2'(WAIT);
    localparam logic [1:0] ST_QUAL    = 2'(QUAL);
    localparam logic [1:0] ST_LOCKED  = 2'(LOCKED);
    localparam logic [1:0] ST_HOLDOFF = 2'(HOLDOFF);

    // Terminal counts, pre-sized to the counters they are compared with.
    localparam logic [CNT_W-1:0]      QUAL_LAST = CNT_W'(QUAL_CYCLES - 1);
    localparam logic [LOSS_CNT_W-1:0] LOSS_LAST = LOSS_CNT_W'(LOSS_FILTER - 1);
    localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]      TO_MAX    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic                  TO_EN     = (TIMEOUT_CYCLES != 0);

    logic                  lock_s;

    logic [1:0]            state_d, state_q;
    logic [CNT_W-1:0]      qual_cnt_d, qual_cnt_q;
    logic [LOSS_CNT_W-1:0] low_cnt_d, low_cnt_q;
    logic [CNT_W-1:0]      hold_cnt_d, hold_cnt_q;
    logic [CNT_W-1:0]      to_cnt_d, to_cnt_q;
    logic                  lock_d, lock_q;
    logic                  lock_lost_d, lock_lost_q;
    logic                  timeout_d, timeout_q;
    logic [LOSS_CNT_W-1:0] loss_cnt_d, loss_cnt_q;

    logic                  loss_evt;
    logic                  to_evt;

    // Bring the raw lock into the clock domain.
    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pll_lock_i),
        .q_o    (lock_s)
    );

    // Qualification FSM: stability window, dropout filter and hold-off.
    always_comb begin
        state_d    = state_q;
        qual_cnt_d = qual_cnt_q;
        low_cnt_d  = low_cnt_q;
        hold_cnt_d = hold_cnt_q;
        loss_evt   = 1'b0;
        case (state_q)
            ST_WAIT: begin
                // The sample that leaves WAIT is the first qualifying one.
                if (lock_s) begin
                    state_d    = ST_QUAL;
                    qual_cnt_d = CNT_W'(1);
                end
            end
            ST_QUAL: begin
                if (!lock_s) begin
                    state_d    = ST_WAIT;
                    qual_cnt_d = '0;
                end else if (qual_cnt_q == QUAL_LAST) begin
                    state_d    = ST_LOCKED;
                    qual_cnt_d = '0;
                    low_cnt_d  = '0;
                end else begin
                    qual_cnt_d = qual_cnt_q + CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (lock_s) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q == LOSS_LAST) begin
                    state_d    = ST_HOLDOFF;
                    low_cnt_d  = '0;
                    hold_cnt_d = '0;
                    loss_evt   = 1'b1;
                end else begin
                    low_cnt_d = low_cnt_q + LOSS_CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                // The PLL is ignored here so a flapping lock cannot bounce
                // straight back into qualification.
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_WAIT;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_WAIT;
                qual_cnt_d = '0;
                low_cnt_d  = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Timeout counter: runs while not locked, saturates, fires once on arrival.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == ST_WAIT || state_q == ST_QUAL) begin
            if (state_d == ST_LOCKED) begin
                to_cnt_d = '0;
            end else begin
                to_cnt_d = sat_inc(to_cnt_q, TO_MAX);
            end
        end
        // Only the transition onto the ceiling fires, so a cleared timeout
        // stays clear while the counter sits saturated.
        to_evt = TO_EN && (to_cnt_q != TO_MAX) && (to_cnt_d == TO_MAX);
    end

    // Sticky status and lock output; a set event beats a same-cycle clear.
    always_comb begin
        lock_d = (state_d == ST_LOCKED);

        if (loss_evt) begin
            lock_lost_d = 1'b1;
        end else if (clr_status_i) begin
            lock_lost_d = 1'b0;
        end else begin
            lock_lost_d = lock_lost_q;
        end

        if (loss_evt) begin
            if (clr_status_i) begin
                loss_cnt_d = LOSS_CNT_W'(1);
            end else if (loss_cnt_q == LOSS_CNT_MAX) begin
                loss_cnt_d = loss_cnt_q;
            end else begin
                loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
            end
        end else if (clr_status_i) begin
            loss_cnt_d = '0;
        end else begin
            loss_cnt_d = loss_cnt_q;
        end

        if (to_evt) begin
            timeout_d = 1'b1;
        end else if (clr_status_i) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // All qualifier state flops.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_WAIT;
            qual_cnt_q  <= '0;
            low_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            to_cnt_q    <= '0;
            lock_q      <= 1'b0;
            lock_lost_q <= 1'b0;
            timeout_q   <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            qual_cnt_q  <= qual_cnt_d;
            low_cnt_q   <= low_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            to_cnt_q    <= to_cnt_d;
            lock_q      <= lock_d;
            lock_lost_q <= lock_lost_d;
            timeout_q   <= timeout_d;
            loss_cnt_q  <= loss_cnt_d;
        end
    end

    // Test mode overrides lock without disturbing the FSM.
    assign lock_o      = lock_q | test_mode_i;
    assign lock_lost_o = lock_lost_q;
    assign timeout_o   = timeout_q;
    assign loss_cnt_o  = loss_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pll_lock_qualifier.sv
// Bench for pll_lock_qualifier with QUAL=8, LOSS=4, HOLDOFF=16, TIMEOUT=100.
// Edge numbers below count rising edges after reset release, starting at 1.
module tb_pll_lock_qualifier;

    localparam int W = 11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pll_lock_qualifier_if bus ();

    pll_lock_qualifier #(
        .QUAL_CYCLES    (8),
        .LOSS_FILTER    (4),
        .HOLDOFF_CYCLES (16),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pll_lock_i   (bus.pll_lock),
        .test_mode_i  (bus.test_mode),
        .clr_status_i (bus.clr_status),
        .lock_o       (bus.lock),
        .lock_lost_o  (bus.lock_lost),
        .timeout_o    (bus.timeout),
        .loss_cnt_o   (bus.loss_cnt),
        .dbg_state_o  (bus.dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs;
    logic [W-1:0] exp_v;
    int           n_total = 0;
    int           n_bad   = 0;

    function automatic logic [W-1:0] ev(input logic l, input logic lost,
                                        input logic to, input logic [7:0] c);
        ev = {l, lost, to, c};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n          = 1'b0;
        bus.pll_lock   = 1'b0;
        bus.test_mode  = 1'b0;
        bus.clr_status = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
        obs = {bus.lock, bus.lock_lost, bus.timeout, bus.loss_cnt};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n          = 1'b0;
        bus.pll_lock   = 1'b1;
        bus.test_mode  = 1'b0;
        bus.clr_status = 1'b0;
        exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 8'd0));
        wait_edge();
        exp_v = exp_q.pop_front();
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h exp=%h", obs, exp_v);
        end
        n_total++;
        if (bus.dbg_state !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_state got=%0d exp=0", bus.dbg_state);
        end
        bus.test_mode = 1'b1;
        #1;
        n_total++;
        if (bus.lock !== 1'b1) begin
            n_bad++;
            $display("FAIL test_mode_on got=%b exp=1", bus.lock);
        end
        bus.test_mode = 1'b0;
        #1;
        n_total++;
        if (bus.lock !== 1'b0) begin
            n_bad++;
            $display("FAIL test_mode_off got=%b exp=0", bus.lock);
        end
    endtask

    task automatic test_lock();
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            bus.pll_lock  = 1'b1;
            bus.test_mode = (e <= 3);
            exp_q.push_back(ev((e >= 10) || (e <= 3), 1'b0, 1'b0, 8'd0));
            wait_edge();
            exp_v = exp_q.pop_front();
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL lock_rise e=%0d got=%h exp=%h", e, obs, exp_v);
            end
        end
        n_total++;
        if (bus.dbg_state !== 2'd2) begin
            n_bad++;
            $display("FAIL lock_state got=%0d exp=2", bus.dbg_state);
        end
    endtask

    task automatic test_glitch_qual();
        do_reset();
        for (int e = 1; e <= 22; e++) begin
            bus.pll_lock = (e <= 5) || (e >= 9);
            exp_q.push_back(ev(e >= 18, 1'b0, 1'b0, 8'd0));
            wait_edge();
            exp_v = exp_q.pop_front();
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL glitch_qual e=%0d got=%h exp=%h", e, obs, exp_v);
            end
        end
    endtask

    // Short dropout, real loss with hold-off and relock, then a loss that
    // coincides with a status clear, then a plain clear.
    task automatic test_loss_holdoff();
        logic l;
        logic lost;
        logic [7:0] c;
        do_reset();
        for (int e = 1; e <= 75; e++) begin
            bus.pll_lock   = !((e >= 15 && e <= 17) || (e >= 27 && e <= 30) ||
                               (e >= 60 && e <= 63));
            bus.clr_status = (e == 65) || (e == 70);
            l    = (e >= 10 && e < 32) || (e >= 56 && e < 65);
            lost = (e >= 32 && e < 70);
            c    = (e >= 32 && e < 70) ? 8'd1 : 8'd0;
            exp_q.push_back(ev(l, lost, 1'b0, c));
            wait_edge();
            exp_v = exp_q.pop_front();
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL loss_holdoff e=%0d got=%h exp=%h", e, obs, exp_v);
            end
        end
        bus.clr_status = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        for (int e = 1; e <= 128; e++) begin
            bus.pll_lock   = (e >= 116);
            bus.clr_status = (e == 106);
            exp_q.push_back(ev(e >= 125, 1'b0, (e >= 100 && e < 106), 8'd0));
            wait_edge();
            exp_v = exp_q.pop_front();
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL timeout e=%0d got=%h exp=%h", e, obs, exp_v);
            end
        end
        bus.clr_status = 1'b0;
    endtask

    // Three losses to reach loss_cnt=3, then a one-edge reset while locked.
    task automatic test_reset_mid();
        logic l;
        logic lost;
        logic [7:0] c;
        do_reset();
        for (int e = 1; e <= 120; e++) begin
            rst_n         = (e != 108);
            bus.pll_lock  = !((e >= 12 && e <= 15) || (e >= 44 && e <= 47) ||
                              (e >= 76 && e <= 79));
            bus.test_mode = (e == 20) || (e == 21);
            l = (e >= 10 && e < 17) || (e >= 41 && e < 49) || (e >= 73 && e < 81) ||
                (e >= 105 && e < 108) || (e >= 118) || (e == 20) || (e == 21);
            lost = (e >= 17 && e < 108);
            if (e < 17)       c = 8'd0;
            else if (e < 49)  c = 8'd1;
            else if (e < 81)  c = 8'd2;
            else if (e < 108) c = 8'd3;
            else              c = 8'd0;
            exp_q.push_back(ev(l, lost, 1'b0, c));
            wait_edge();
            exp_v = exp_q.pop_front();
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL reset_mid e=%0d got=%h exp=%h", e, obs, exp_v);
            end
            if (e == 108) begin
                n_total++;
                if (bus.dbg_state !== 2'd0) begin
                    n_bad++;
                    $display("FAIL reset_mid_state got=%0d exp=0", bus.dbg_state);
                end
            end
        end
        rst_n         = 1'b1;
        bus.test_mode = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n          = 1'b0;
        bus.pll_lock   = 1'b0;
        bus.test_mode  = 1'b0;
        bus.clr_status = 1'b0;
        test_reset();
        test_lock();
        test_glitch_qual();
        test_loss_holdoff();
        test_timeout();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
